// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed 7-segment scanner with per-slot blanking and a per-frame segment snapshot.
// Optional build macro SEG7_SCAN_DIM_EN adds a dim[2:0] input for frame-skipping brightness control.
module seg7_scan_mux #(
   parameter int SEG7_NUM       = 8,
   parameter bit LOW_ACTIVE     = 1'b1,
   parameter bit DIG_LOW_ACTIVE = 1'b1,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYCLES   = 500
) (
   input  logic                  avs_s1_clk,
   input  logic                  avs_s1_reset_n,
   input  logic [8*SEG7_NUM-1:0] seg_in,
   input  logic                  scan_en,
`ifdef SEG7_SCAN_DIM_EN
   input  logic [2:0]            dim,
`endif
   output logic [7:0]            seg_out,
   output logic [SEG7_NUM-1:0]   dig_sel,
   output logic                  frame_tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(SEG7_NUM);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(SEG7_NUM - 1);
   localparam logic [7:0]          SEG_OFF = {8{LOW_ACTIVE}};
   localparam logic [SEG7_NUM-1:0] DIG_OFF = {SEG7_NUM{DIG_LOW_ACTIVE}};

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [8*SEG7_NUM-1:0] snap_q, snap_d;
   logic                  tick_q, tick_d;
   logic                  frame_lit;
   logic [SEG7_NUM-1:0]   dig_onehot;

`ifdef SEG7_SCAN_DIM_EN
   logic [2:0] fc_q, fc_d;
   logic [2:0] dim_q, dim_d;

   // Frames numbered below the sampled dim level stay dark, giving (8-dim)/8 duty.
   assign frame_lit = (fc_q >= dim_q);
`else
   assign frame_lit = 1'b1;
`endif

   assign dig_onehot = {{(SEG7_NUM-1){1'b0}}, 1'b1} << idx_q;

   always_ff @(posedge avs_s1_clk) begin
      if (!avs_s1_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         tick_q  <= 1'b0;
`ifdef SEG7_SCAN_DIM_EN
         fc_q    <= '0;
         dim_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         tick_q  <= tick_d;
`ifdef SEG7_SCAN_DIM_EN
         fc_q    <= fc_d;
         dim_q   <= dim_d;
`endif
      end
   end

   // Dropping scan_en overrides everything, including a wrap on the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      tick_d  = 1'b0;
`ifdef SEG7_SCAN_DIM_EN
      fc_d    = fc_q;
      dim_d   = dim_q;
`endif
      if (!scan_en) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = '0;
               snap_d  = seg_in;
               tick_d  = 1'b1;
`ifdef SEG7_SCAN_DIM_EN
               dim_d   = dim;
`endif
            end
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DRIVE: begin
               if (cnt_q == DRIVE_LAST) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  if (idx_q == IDX_LAST) begin
                     idx_d  = '0;
                     snap_d = seg_in;
                     tick_d = 1'b1;
`ifdef SEG7_SCAN_DIM_EN
                     fc_d   = fc_q + 3'd1;
                     dim_d  = dim;
`endif
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output stage lags the scan state by one cycle so every pin is a clean flop.
   always_ff @(posedge avs_s1_clk) begin
      if (!avs_s1_reset_n) begin
         seg_out    <= SEG_OFF;
         dig_sel    <= DIG_OFF;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= tick_q;
         if (state_q == DRIVE) begin
            dig_sel <= DIG_LOW_ACTIVE ? ~dig_onehot : dig_onehot;
            seg_out <= frame_lit ? snap_q[{idx_q, 3'b000} +: 8] : SEG_OFF;
         end else begin
            dig_sel <= DIG_OFF;
            seg_out <= SEG_OFF;
         end
      end
   end

endmodule
